// File: rtl/ima_adpcm_dec.sv
// IMA ADPCM decoder: 4-bit codes in, 16-bit PCM out, bit-exact with the encoder's predictor.
// Optional block-header init ports are enabled with `define ADPCM_DEC_INIT_EN.
module ima_adpcm_dec (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  inPCM,
  input  logic        inValid,
  output logic        inReady,
`ifdef ADPCM_DEC_INIT_EN
  input  logic        initValid,
  input  logic [15:0] initSamp,
  input  logic [6:0]  initIndex,
`endif
  output logic [15:0] outSamp,
  output logic        outValid,
  output logic [15:0] outPredictSamp,
  output logic [6:0]  outStepIndex
);

  typedef enum logic [2:0] {
    DEC_IDLE = 3'd0,
    DEC_BIT2 = 3'd1,
    DEC_BIT1 = 3'd2,
    DEC_BIT0 = 3'd3,
    DEC_DONE = 3'd4
  } dec_state_t;

  dec_state_t         r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [3:0]         r_code;
  logic signed [18:0] r_pred;
  logic [18:0]        r_dequant;
  logic [6:0]         r_step_index;
  logic [14:0]        r_step_size;

  logic signed [20:0] w_pre_sum;
  logic signed [18:0] w_pred_next;
  logic [6:0]         w_index_next;

  function automatic logic [14:0] step_lut(input logic [6:0] idx);
    case (idx)
      7'd0:  step_lut = 15'd7;     7'd1:  step_lut = 15'd8;     7'd2:  step_lut = 15'd9;     7'd3:  step_lut = 15'd10;
      7'd4:  step_lut = 15'd11;    7'd5:  step_lut = 15'd12;    7'd6:  step_lut = 15'd13;    7'd7:  step_lut = 15'd14;
      7'd8:  step_lut = 15'd16;    7'd9:  step_lut = 15'd17;    7'd10: step_lut = 15'd19;    7'd11: step_lut = 15'd21;
      7'd12: step_lut = 15'd23;    7'd13: step_lut = 15'd25;    7'd14: step_lut = 15'd28;    7'd15: step_lut = 15'd31;
      7'd16: step_lut = 15'd34;    7'd17: step_lut = 15'd37;    7'd18: step_lut = 15'd41;    7'd19: step_lut = 15'd45;
      7'd20: step_lut = 15'd50;    7'd21: step_lut = 15'd55;    7'd22: step_lut = 15'd60;    7'd23: step_lut = 15'd66;
      7'd24: step_lut = 15'd73;    7'd25: step_lut = 15'd80;    7'd26: step_lut = 15'd88;    7'd27: step_lut = 15'd97;
      7'd28: step_lut = 15'd107;   7'd29: step_lut = 15'd118;   7'd30: step_lut = 15'd130;   7'd31: step_lut = 15'd143;
      7'd32: step_lut = 15'd157;   7'd33: step_lut = 15'd173;   7'd34: step_lut = 15'd190;   7'd35: step_lut = 15'd209;
      7'd36: step_lut = 15'd230;   7'd37: step_lut = 15'd253;   7'd38: step_lut = 15'd279;   7'd39: step_lut = 15'd307;
      7'd40: step_lut = 15'd337;   7'd41: step_lut = 15'd371;   7'd42: step_lut = 15'd408;   7'd43: step_lut = 15'd449;
      7'd44: step_lut = 15'd494;   7'd45: step_lut = 15'd544;   7'd46: step_lut = 15'd598;   7'd47: step_lut = 15'd658;
      7'd48: step_lut = 15'd724;   7'd49: step_lut = 15'd796;   7'd50: step_lut = 15'd876;   7'd51: step_lut = 15'd963;
      7'd52: step_lut = 15'd1060;  7'd53: step_lut = 15'd1166;  7'd54: step_lut = 15'd1282;  7'd55: step_lut = 15'd1411;
      7'd56: step_lut = 15'd1552;  7'd57: step_lut = 15'd1707;  7'd58: step_lut = 15'd1878;  7'd59: step_lut = 15'd2066;
      7'd60: step_lut = 15'd2272;  7'd61: step_lut = 15'd2499;  7'd62: step_lut = 15'd2749;  7'd63: step_lut = 15'd3024;
      7'd64: step_lut = 15'd3327;  7'd65: step_lut = 15'd3660;  7'd66: step_lut = 15'd4026;  7'd67: step_lut = 15'd4428;
      7'd68: step_lut = 15'd4871;  7'd69: step_lut = 15'd5358;  7'd70: step_lut = 15'd5894;  7'd71: step_lut = 15'd6484;
      7'd72: step_lut = 15'd7132;  7'd73: step_lut = 15'd7845;  7'd74: step_lut = 15'd8630;  7'd75: step_lut = 15'd9493;
      7'd76: step_lut = 15'd10442; 7'd77: step_lut = 15'd11487; 7'd78: step_lut = 15'd12635; 7'd79: step_lut = 15'd13899;
      7'd80: step_lut = 15'd15289; 7'd81: step_lut = 15'd16818; 7'd82: step_lut = 15'd18500; 7'd83: step_lut = 15'd20350;
      7'd84: step_lut = 15'd22385; 7'd85: step_lut = 15'd24623; 7'd86: step_lut = 15'd27086; 7'd87: step_lut = 15'd29794;
      default: step_lut = 15'd32767;
    endcase
  endfunction

  function automatic logic signed [18:0] sat_pred(input logic signed [20:0] pre);
    if (pre < -21'sd262144)
      sat_pred = 19'sh40000;
    else if (pre > 21'sd262143)
      sat_pred = 19'sh3FFFF;
    else
      sat_pred = pre[18:0];
  endfunction

  // Drops the 3 fraction bits with round-half-up, never wrapping positive full scale.
  function automatic logic [15:0] round_out(input logic [16:0] p_hi);
    if (p_hi[16:1] == 16'h7FFF)
      round_out = 16'h7FFF;
    else
      round_out = p_hi[16:1] + {15'd0, p_hi[0]};
  endfunction

  function automatic logic [6:0] next_index(input logic [6:0] idx, input logic [2:0] mag);
    logic signed [7:0] s;
    logic signed [7:0] delta;
    case (mag)
      3'd4:    delta = 8'sd2;
      3'd5:    delta = 8'sd4;
      3'd6:    delta = 8'sd6;
      3'd7:    delta = 8'sd8;
      default: delta = -8'sd1;
    endcase
    s = $signed({1'b0, idx}) + delta;
    if (s < 8'sd0)
      next_index = 7'd0;
    else if (s > 8'sd88)
      next_index = 7'd88;
    else
      next_index = s[6:0];
  endfunction

  // Sum carried 21 bits wide: sign-extended predictor plus up to 15*32767 never overflows.
  assign w_pre_sum    = r_code[3] ? (21'(r_pred) - $signed({2'b00, r_dequant}))
                                  : (21'(r_pred) + $signed({2'b00, r_dequant}));
  assign w_pred_next  = sat_pred(w_pre_sum);
  assign w_index_next = next_index(r_step_index, r_code[2:0]);

  always_ff @(posedge clock) begin
    r_step_size <= step_lut(r_step_index);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= DEC_IDLE;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_code       <= 4'd0;
      r_pred       <= 19'sd0;
      r_dequant    <= 19'd0;
      r_step_index <= 7'd0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        DEC_IDLE: begin
`ifdef ADPCM_DEC_INIT_EN
          if (initValid && r_in_ready) begin
            r_pred       <= $signed({initSamp, 3'b000});
            r_step_index <= (initIndex > 7'd88) ? 7'd88 : initIndex;
            r_in_ready   <= 1'b1;
          end else
`endif
          if (inValid && r_in_ready) begin
            r_code     <= inPCM;
            r_in_ready <= 1'b0;
            r_state    <= DEC_BIT2;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        DEC_BIT2: begin
          r_dequant <= {4'd0, r_step_size} + (r_code[2] ? {1'b0, r_step_size, 3'b000} : 19'd0);
          r_state   <= DEC_BIT1;
        end
        DEC_BIT1: begin
          if (r_code[1])
            r_dequant <= r_dequant + {2'b00, r_step_size, 2'b00};
          r_state <= DEC_BIT0;
        end
        DEC_BIT0: begin
          if (r_code[0])
            r_dequant <= r_dequant + {3'b000, r_step_size, 1'b0};
          r_state <= DEC_DONE;
        end
        DEC_DONE: begin
          r_pred       <= w_pred_next;
          r_step_index <= w_index_next;
          r_out_valid  <= 1'b1;
          r_in_ready   <= 1'b1;
          r_state      <= DEC_IDLE;
        end
        default: r_state <= DEC_IDLE;
      endcase
    end
  end

  assign inReady        = r_in_ready;
  assign outValid       = r_out_valid;
  assign outSamp        = round_out(r_pred[18:2]);
  assign outPredictSamp = outSamp;
  assign outStepIndex   = r_step_index;

endmodule

// File: tb/tb_ima_adpcm_dec.sv
// Randomized bench for ima_adpcm_dec against an integer-arithmetic IMA reference model.
module tb_ima_adpcm_dec;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  inPCM = 4'd0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] outSamp;
  logic        outValid;
  logic [15:0] outPredictSamp;
  logic [6:0]  outStepIndex;
`ifdef ADPCM_DEC_INIT_EN
  logic        initValid = 1'b0;
  logic [15:0] initSamp = 16'd0;
  logic [6:0]  initIndex = 7'd0;
`endif

  ima_adpcm_dec dut (
    .clock(clock), .reset(reset), .inPCM(inPCM), .inValid(inValid), .inReady(inReady),
`ifdef ADPCM_DEC_INIT_EN
    .initValid(initValid), .initSamp(initSamp), .initIndex(initIndex),
`endif
    .outSamp(outSamp), .outValid(outValid), .outPredictSamp(outPredictSamp),
    .outStepIndex(outStepIndex)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int m_pred = 0;
  int m_idx = 0;
  int steps [0:88] = '{7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41,
    45, 50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279,
    307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411,
    1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894,
    6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350,
    22385, 24623, 27086, 29794, 32767};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic void model_step(input logic [3:0] c);
    int mag = int'(c[2:0]);
    int dq  = steps[m_idx] * (2 * mag + 1);
    m_pred = c[3] ? m_pred - dq : m_pred + dq;
    if (m_pred > 262143) m_pred = 262143;
    if (m_pred < -262144) m_pred = -262144;
    m_idx = (mag < 4) ? m_idx - 1 : m_idx + 2 * (mag - 3);
    if (m_idx < 0) m_idx = 0;
    if (m_idx > 88) m_idx = 88;
  endfunction

  function automatic logic [15:0] exp_samp(input int p);
    int hi = p >>> 3;
    if (hi == 32767) return 16'h7FFF;
    return 16'(hi + ((p >> 2) & 1));
  endfunction

  // Called on a falling edge; returns on the falling edge where outValid is seen.
  task automatic do_code(input logic [3:0] c, output int waited);
    int lat;
    inPCM = c;
    inValid = 1'b1;
    waited = 0;
    while (!inReady && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!inReady) begin
      chk("ready_timeout", 32'(inReady), 32'd1);
      inValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inPCM = 4'($urandom);
    model_step(c);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!outValid && lat < 10);
    chk("latency", 32'(lat), 32'd5);
    chk("outSamp", 32'(outSamp), 32'(exp_samp(m_pred)));
    chk("outPredictSamp", 32'(outPredictSamp), 32'(exp_samp(m_pred)));
    chk("outStepIndex", 32'(outStepIndex), 32'(m_idx));
    chk("ready_on_valid", 32'(inReady), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    inValid = 1'b0;
    repeat (cycles) @(negedge clock);
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_outSamp", 32'(outSamp), 32'd0);
    chk("rst_index", 32'(outStepIndex), 32'd0);
    reset = 1'b0;
    m_pred = 0;
    m_idx = 0;
  endtask

  initial begin
    int w;
    int gap;
    do_reset(3);
    @(negedge clock);
    chk("ready_after_reset", 32'(inReady), 32'd1);

    do_code(4'h7, w);
    chk("c7_samp", 32'(outSamp), 32'd13);
    chk("c7_index", 32'(outStepIndex), 32'd8);

    do_reset(2);
    do_code(4'h0, w);
    chk("c0_samp", 32'(outSamp), 32'd1);
    chk("c0_index", 32'(outStepIndex), 32'd0);

    do_reset(2);
    do_code(4'h7, w);
    do_code(4'h8, w);
    chk("b2b_wait", 32'(w), 32'd0);
    chk("b2b_samp", 32'(outSamp), 32'd11);
    chk("b2b_index", 32'(outStepIndex), 32'd7);

    do_reset(2);
    for (int i = 0; i < 16; i++) do_code(4'h7, w);
    chk("sat_pos_samp", 32'(outSamp), 32'h7FFF);
    chk("sat_pos_index", 32'(outStepIndex), 32'd88);
    for (int i = 0; i < 16; i++) do_code(4'hF, w);
    chk("sat_neg_samp", 32'(outSamp), 32'h8000);

    // Abort a decode in flight with a one-cycle reset.
    @(negedge clock);
    inPCM = 4'h7;
    inValid = 1'b1;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_pred = 0;
    m_idx = 0;
    chk("abort_samp", 32'(outSamp), 32'd0);
    chk("abort_index", 32'(outStepIndex), 32'd0);
    chk("abort_ready_low", 32'(inReady), 32'd0);
    @(negedge clock);
    chk("abort_ready_high", 32'(inReady), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", 32'(outValid), 32'd0);
      @(negedge clock);
    end

`ifdef ADPCM_DEC_INIT_EN
    initValid = 1'b1;
    initSamp = 16'd1000;
    initIndex = 7'd100;
    inPCM = 4'h5;
    inValid = 1'b1;
    @(negedge clock);
    initValid = 1'b0;
    inValid = 1'b0;
    m_pred = 8000;
    m_idx = 88;
    chk("init_ready", 32'(inReady), 32'd1);
    chk("init_no_valid", 32'(outValid), 32'd0);
    chk("init_samp", 32'(outSamp), 32'd1000);
    chk("init_index", 32'(outStepIndex), 32'd88);
    @(negedge clock);
    chk("init_not_accepted", 32'(outValid), 32'd0);
    do_code(4'h0, w);
    chk("init_dec_index", 32'(outStepIndex), 32'd87);
`endif

    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        chk("pulse_width", 32'(outValid), 32'd0);
        chk("hold_samp", 32'(outSamp), 32'(exp_samp(m_pred)));
      end
      do_code(4'($urandom), w);
      if ((i % 97) == 96) do_reset(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
